// File: rtl/note_word_identifier_pkg.sv
// Shared definitions for the note word identifier: FSM state encodings,
// word class (tipo) codes, note constants and note classification helpers.
package note_word_identifier_pkg;

  // FSM states; the numeric values are exported on estado_atual.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_ADJ1 = 4'b0001,
    ST_ADJ2 = 4'b0010,
    ST_CMP1 = 4'b0011,
    ST_CMP2 = 4'b0100,
    ST_CMP3 = 4'b0101,
    ST_ADV1 = 4'b0110,
    ST_ADV2 = 4'b0111,
    ST_ADV3 = 4'b1000
  } state_e;

  // Word class codes reported on tipo.
  localparam logic [1:0] TIPO_NONE = 2'b00;
  localparam logic [1:0] TIPO_ADJ  = 2'b01;
  localparam logic [1:0] TIPO_CMP  = 2'b10;
  localparam logic [1:0] TIPO_ADV  = 2'b11;

  // Named notes used by the final-note validation rules.
  localparam logic [3:0] LA_BAIXO = 4'b0110;
  localparam logic [3:0] SI_BAIXO = 4'b0111;
  localparam logic [3:0] DO_ALTO  = 4'b1000;
  localparam logic [3:0] RE_ALTO  = 4'b1010;

  // Upper bounds of the first-note ranges that select each word class.
  localparam logic [3:0] ADJ_FIRST_MAX = 4'b0011;
  localparam logic [3:0] CMP_FIRST_MAX = 4'b1011;

  // "Low" notes are la-baixo and si-baixo.
  function automatic logic isLowNote(input logic [3:0] n);
    return (n == LA_BAIXO) || (n == SI_BAIXO);
  endfunction

  // "High" notes span 1000..1011 (do-alto through the note above re-alto).
  function automatic logic isHighNote(input logic [3:0] n);
    return (n[3:2] == DO_ALTO[3:2]);
  endfunction

endpackage

// File: rtl/note_seg7_decoder.sv
// Combinational hex-to-7-segment decoder for the current note code.
// Segment outputs are active-high, seg[0] = a through seg[6] = g.
module note_seg7_decoder
  import note_word_identifier_pkg::*;
(
  input  logic [3:0] nota,
  output logic [6:0] seg
);

  // Standard hex glyph table, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg = 7'b0000000;
    case (nota)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/note_word_identifier.sv
// Groups a stream of confirmed notes into words, classifies each finished
// word (adjective, comparative, adverb) and validates its final notes.
// A one-cycle fim pulse marks completion; tipo holds the last result.
// The 7-segment display of the current note is purely combinational.
module note_word_identifier
  import note_word_identifier_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ok,
  input  logic [3:0] nota,
  output logic       fim,
  output logic [1:0] tipo,
  output logic [3:0] estado_atual,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  output logic       s5,
  output logic       s6
);

  state_e     state_q, state_d;
  logic       ok_q;
  logic       valid_q, valid_d;
  logic [1:0] tipo_q, tipo_d;
  logic       fim_q, fim_d;
  logic       accept;
  logic [6:0] seg;

  // A note is confirmed only on the rising edge of ok, so a held strobe
  // (including one held through reset) yields at most one note.
  assign accept = ok & ~ok_q;

  // Registers: reset forces ok_q high so a stuck-high ok is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ok_q    <= 1'b1;
      valid_q <= 1'b0;
      tipo_q  <= TIPO_NONE;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ok_q    <= ok;
      valid_q <= valid_d;
      tipo_q  <= tipo_d;
      fim_q   <= fim_d;
    end
  end

  // Next-state logic: walk the chain chosen by the first note, track the
  // validity of notes 3/4, and publish the class on the final note.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tipo_d  = tipo_q;
    fim_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          valid_d = 1'b0;
          if (nota <= ADJ_FIRST_MAX) begin
            state_d = ST_ADJ1;
          end else if (nota <= CMP_FIRST_MAX) begin
            state_d = ST_CMP1;
          end else begin
            state_d = ST_ADV1;
          end
        end
      end
      ST_ADJ1: begin
        if (accept) state_d = ST_ADJ2;
      end
      ST_ADJ2: begin
        if (accept) begin
          state_d = ST_IDLE;
          fim_d   = 1'b1;
          valid_d = 1'b0;
          tipo_d  = isLowNote(nota) ? TIPO_ADJ : TIPO_NONE;
        end
      end
      ST_CMP1: begin
        if (accept) state_d = ST_CMP2;
      end
      ST_CMP2: begin
        if (accept) begin
          state_d = ST_CMP3;
          valid_d = isHighNote(nota);
        end
      end
      ST_CMP3: begin
        if (accept) begin
          state_d = ST_IDLE;
          fim_d   = 1'b1;
          valid_d = 1'b0;
          tipo_d  = (valid_q || isHighNote(nota)) ? TIPO_CMP : TIPO_NONE;
        end
      end
      ST_ADV1: begin
        if (accept) state_d = ST_ADV2;
      end
      ST_ADV2: begin
        if (accept) begin
          state_d = ST_ADV3;
          valid_d = (nota == LA_BAIXO);
        end
      end
      ST_ADV3: begin
        if (accept) begin
          state_d = ST_IDLE;
          fim_d   = 1'b1;
          valid_d = 1'b0;
          tipo_d  = (valid_q && (nota == SI_BAIXO)) ? TIPO_ADV : TIPO_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign fim          = fim_q;
  assign tipo         = tipo_q;
  assign estado_atual = state_q;

  note_seg7_decoder u_seg7 (
    .nota (nota),
    .seg  (seg)
  );

  assign s0 = seg[0];
  assign s1 = seg[1];
  assign s2 = seg[2];
  assign s3 = seg[3];
  assign s4 = seg[4];
  assign s5 = seg[5];
  assign s6 = seg[6];

endmodule

// File: tb/tb_note_word_identifier.sv
// Self-checking bench for note_word_identifier: directed words, handshake
// and reset corner cases, random note streams and a segment sweep, all
// checked against a note-list reference model.
module tb_note_word_identifier;

  logic       clk = 1'b0;
  logic       reset;
  logic       ok;
  logic [3:0] nota;
  logic       fim;
  logic [1:0] tipo;
  logic [3:0] estado_atual;
  logic       s0, s1, s2, s3, s4, s5, s6;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: notes of the word in progress plus expected outputs.
  int         wordNotes[$];
  logic [1:0] expTipo;
  logic       expFim;

  note_word_identifier dut (
    .clk          (clk),
    .reset        (reset),
    .ok           (ok),
    .nota         (nota),
    .fim          (fim),
    .tipo         (tipo),
    .estado_atual (estado_atual),
    .s0           (s0),
    .s1           (s1),
    .s2           (s2),
    .s3           (s3),
    .s4           (s4),
    .s5           (s5),
    .s6           (s6)
  );

  always #5 clk = ~clk;

  function automatic int wordClass(input int first);
    if (first < 4) return 1;
    if (first < 12) return 2;
    return 3;
  endfunction

  function automatic int wordLen(input int first);
    return (first < 4) ? 3 : 4;
  endfunction

  function automatic bit isHigh(input int n);
    return (n >= 8) && (n <= 11);
  endfunction

  // State number = chain base for the class plus notes taken so far.
  function automatic logic [7:0] modelState();
    int k;
    if (wordNotes.size() == 0) return 8'd0;
    k = wordNotes.size();
    case (wordClass(wordNotes[0]))
      1:       return 8'(k);
      2:       return 8'(2 + k);
      default: return 8'(5 + k);
    endcase
  endfunction

  function automatic bit wordValid();
    case (wordClass(wordNotes[0]))
      1:       return (wordNotes[2] == 6) || (wordNotes[2] == 7);
      2:       return isHigh(wordNotes[2]) || isHigh(wordNotes[3]);
      default: return (wordNotes[2] == 6) && (wordNotes[3] == 7);
    endcase
  endfunction

  task automatic modelAccept(input int n);
    wordNotes.push_back(n);
    if (wordNotes.size() == wordLen(wordNotes[0])) begin
      expFim  = 1'b1;
      expTipo = wordValid() ? 2'(wordClass(wordNotes[0])) : 2'b00;
      wordNotes.delete();
    end else begin
      expFim = 1'b0;
    end
  endtask

  task automatic modelReset();
    wordNotes.delete();
    expTipo = 2'b00;
    expFim  = 1'b0;
  endtask

  // Segment list per hex digit, written as the lit segment letters.
  function automatic logic [6:0] segMask(input int v);
    string lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                       "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                       "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    string s;
    logic [6:0] m;
    m = 7'b0;
    s = lit[v];
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b1;
    return m;
  endfunction

  task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".estado"}, {4'b0, estado_atual}, modelState());
    checkEq({tag, ".fim"}, {7'b0, fim}, {7'b0, expFim});
    checkEq({tag, ".tipo"}, {6'b0, tipo}, {6'b0, expTipo});
  endtask

  // One confirm: ok high for one cycle, then low for one cycle.
  task automatic applyStimulus(input int n, input string tag);
    @(negedge clk);
    nota = 4'(n);
    ok   = 1'b1;
    @(posedge clk);
    modelAccept(n);
    #1 checkOutput(tag);
    @(negedge clk);
    ok = 1'b0;
    @(posedge clk);
    expFim = 1'b0;
    #1 checkOutput({tag, ".after"});
  endtask

  task automatic idleCycles(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      expFim = 1'b0;
      #1 checkOutput(tag);
    end
  endtask

  initial begin
    int n;
    reset = 1'b0;
    ok    = 1'b0;
    nota  = 4'b0;
    modelReset();

    // Reset state
    repeat (2) @(posedge clk);
    #1 checkOutput("reset");
    @(negedge clk);
    reset = 1'b1;
    idleCycles(3, "idle");

    // Adjective words
    applyStimulus(4'b0001, "adjA1");
    applyStimulus(4'b0011, "adjA2");
    applyStimulus(4'b0110, "adjA3");
    applyStimulus(4'b0010, "adjB1");
    applyStimulus(4'b0011, "adjB2");
    applyStimulus(4'b0111, "adjB3");

    // Comparative words
    applyStimulus(4'b0100, "cmpA1");
    applyStimulus(4'b0101, "cmpA2");
    applyStimulus(4'b0110, "cmpA3");
    applyStimulus(4'b1000, "cmpA4");
    applyStimulus(4'b1001, "cmpB1");
    applyStimulus(4'b1011, "cmpB2");
    applyStimulus(4'b1010, "cmpB3");
    applyStimulus(4'b0111, "cmpB4");

    // Adverb words, valid then invalid
    applyStimulus(4'b1100, "advA1");
    applyStimulus(4'b1101, "advA2");
    applyStimulus(4'b0110, "advA3");
    applyStimulus(4'b0111, "advA4");
    applyStimulus(4'b1110, "advB1");
    applyStimulus(4'b1111, "advB2");
    applyStimulus(4'b0111, "advB3");
    applyStimulus(4'b0110, "advB4");

    // ok held high for 5 cycles takes exactly one note
    @(negedge clk);
    nota = 4'b0100;
    ok   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      if (i == 0) modelAccept(4);
      else expFim = 1'b0;
      #1 checkOutput("holdOk");
    end
    @(negedge clk);
    ok = 1'b0;
    idleCycles(1, "holdOkLow");
    applyStimulus(4'b0101, "holdCmp2");
    applyStimulus(4'b1000, "holdCmp3");
    applyStimulus(4'b0001, "holdCmp4");

    // ok high through reset is not a confirm after release
    @(negedge clk);
    ok    = 1'b1;
    nota  = 4'b0001;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();
    #1 checkOutput("okThruReset");
    @(negedge clk);
    reset = 1'b1;
    idleCycles(2, "okHeldAfterReset");
    @(negedge clk);
    ok = 1'b0;
    idleCycles(1, "okDropped");
    applyStimulus(4'b0000, "postReset1");
    applyStimulus(4'b0001, "postReset2");
    applyStimulus(4'b0111, "postReset3");

    // Reset in the middle of a comparative word (state 0101)
    applyStimulus(4'b0100, "midCmp1");
    applyStimulus(4'b0101, "midCmp2");
    applyStimulus(4'b1001, "midCmp3");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    modelReset();
    #1 checkOutput("midReset");
    @(negedge clk);
    reset = 1'b1;
    idleCycles(1, "midResetRelease");

    // Random note stream, final notes biased toward the validated range
    for (int i = 0; i < 120; i++) begin
      if (wordNotes.size() >= 2 && $urandom_range(0, 1) == 1)
        n = int'($urandom_range(6, 11));
      else
        n = int'($urandom_range(0, 15));
      applyStimulus(n, "rand");
      idleCycles(int'($urandom_range(0, 2)), "randGap");
    end

    // Segment sweep, no clock edge involved in each check
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      nota = 4'(v);
      #1 checkEq("seg", {1'b0, s6, s5, s4, s3, s2, s1, s0}, {1'b0, segMask(v)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/note_word_identifier.md
Name: note_word_identifier

Overview:
- Accepts a stream of 4-bit musical note codes, one note per rising edge of the `ok` strobe.
- Groups the notes into words and classifies each completed word as adjective, comparative or adverb.
- Reports completion with a one-cycle `fim` pulse, a held `tipo` code, and the FSM state on `estado_atual`.
- Also drives a combinational 7-segment display of the current note.
- Sits between the note-entry front panel and the sentence-level parser.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- ok  input  1  note-confirm strobe; level, must be high for at least one clk cycle.
- nota  input  4  note code; nota[0]=D (LSB), nota[1]=N1, nota[2]=N2, nota[3]=N3 (MSB).
- fim  output  1  one-cycle pulse when a word completes.
- tipo  output  2  class of last completed word: 00 invalid/none, 01 adjective, 10 comparative, 11 adverb.
- estado_atual  output  4  current FSM state encoding.
- s0..s6  output  1 each  7-segment drive, segments a..g, active-high.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, estado_atual=0000, fim=0, tipo=00.
  - internal ok_q=1, so an ok held high through reset is not taken as a confirm.
- Confirm event (accept):
  - accept = ok & ~ok_q at a clk edge; ok_q <= ok every cycle.
  - nota is sampled at that same edge.
  - At most one note is accepted per ok high period.
- Word class is fixed by the first note accepted in IDLE:
  - 0000-0011 -> adjective, 3 notes.
  - 0100-1011 -> comparative, 4 notes.
  - 1100-1111 -> adverb, 4 notes.
- States (estado_atual):
  - IDLE 0000
  - ADJ1 0001, ADJ2 0010
  - CMP1 0011, CMP2 0100, CMP3 0101
  - ADV1 0110, ADV2 0111, ADV3 1000
  - 1001-1111 unused; any unused state returns to IDLE on the next edge.
- Each accept advances one state along the chosen chain. The final accept (from ADJ2, CMP3 or ADV3) returns to IDLE. Without an accept, the state holds.
- Validation of final notes ("low" notes: la-baixo 0110, si-baixo 0111; "high" notes: 1000-1011):
  - Adjective: note 3 must be 0110 or 0111.
  - Comparative: at least one of notes 3 and 4 must be in 1000-1011.
  - Adverb: note 3 must be 0110 and note 4 must be 0111.
  - Notes 1 and 2 are unconstrained beyond the class range of note 1.
- Validity is tracked with a registered flag updated on notes 3 and 4.
- On the final accept edge:
  - fim <= 1 for exactly one cycle.
  - tipo <= class code if valid, else 00.
  - tipo holds until the next word completes or reset.
- Latency: fim, tipo and estado_atual become visible in the cycle after the accepting edge.
- Back-to-back words: a new word may start on the very next accept after completion. A new first note while fim is high is legal.
- Reset mid-word discards the partial word; tipo returns to 00.
- The 7-segment output is purely combinational from nota, independent of clk and reset:
  - Displays the hex value {N3,N2,N1,D} with standard a-g patterns.
  - Examples: 0 -> a,b,c,d,e,f on; 1 -> b,c; 8 -> all on; F -> a,e,f,g.

Decomposition:
- Shared package:
  - state encodings (IDLE..ADV3);
  - tipo codes TIPO_NONE, TIPO_ADJ, TIPO_CMP, TIPO_ADV;
  - note constants LA_BAIXO=0110, SI_BAIXO=0111, DO_ALTO=1000, RE_ALTO=1010.
- One natural sub-module: note_seg7_decoder (4-bit in, 7 segments out, combinational), instantiated by note_word_identifier alongside the FSM.

Test Plan:
- Reset held low 2 cycles with ok=0 -> estado_atual=0000, fim=0, tipo=00; release, no activity -> state stays 0000.
- Adjective word: confirm 0001, 0011, 0110 -> states 0001, 0010, then 0000; one-cycle fim; tipo=01. Repeat with 0010, 0011, 0111 -> tipo=01.
- Comparative words: 0100, 0101, 0110, 1000 -> states 0011, 0100, 0101, 0000; fim pulse; tipo=10. Then 1001, 1011, 1010, 0111 -> tipo=10.
- Adverb words: 1100, 1101, 0110, 0111 -> states 0110, 0111, 1000, 0000; tipo=11. Invalid adverb 1110, 1111, 0111, 0110 -> fim pulse with tipo=00.
- Handshake/boundary cases:
  - ok held high 5 cycles -> exactly one note accepted.
  - ok high during reset, reset released -> no accept until ok falls and rises again.
  - Reset asserted in state 0101 -> 0000 next cycle, tipo=00, no fim.
- Segment sweep: nota 0000..1111 -> s0..s6 match the hex 7-segment table (e.g. 0110 -> a,c,d,e,f,g on; b off), changing with no clock.
